instr_fetch_unit: RTL

//  Initiator side of the instruction-memory interface. Owns the PC, drives

---
 rtl/instr_fetch_unit.sv | 70 +++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and ROM fetch initiator with prefetch FIFO and valid/ready handoff to decode; optional halt-on-STOP_WORD via `FETCH_HALT_EN
// Ports: clk, reset (sync active-high), rom_address/rom_enable/rom_data (combinational ROM),
//        if_valid/if_ready/if_instr/if_pc (decode handshake), redirect_valid/redirect_target (execute),
//        halted (stopped on STOP_WORD, only with FETCH_HALT_EN defined, else constant 0)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2,
  parameter logic [31:0] STOP_WORD = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_address,
  output logic        rom_enable,
  input  logic [31:0] rom_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  typedef enum logic {FETCH, HALT} state_t;
  state_t state;
  logic [31:0] pc;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [63:0] mem [FIFO_DEPTH];
  logic full, pop, stop, push;
  always_comb begin
    count = wr_ptr - rd_ptr;
    // depth is a power of two, so the count MSB alone marks full
    full = count[AW];
    if_valid = wr_ptr != rd_ptr;
    pop = if_valid && if_ready;
    // a same-cycle pop frees the slot this fetch will fill
    rom_enable = state == FETCH && !reset && !redirect_valid && (!full || pop);
    rom_address = pc;
    stop = HALT_EN && rom_enable && rom_data == STOP_WORD;
    push = rom_enable && !stop;
    {if_pc, if_instr} = mem[rd_ptr[AW-1:0]];
    halted = HALT_EN && state == HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      state <= FETCH;
    end else if (redirect_valid) begin
      pc <= redirect_target & ~32'd3;
      wr_ptr <= '0;
      rd_ptr <= '0;
      state <= FETCH;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {pc, rom_data};
        wr_ptr <= wr_ptr + 1'b1;
        pc <= pc + 32'd4;
      end
      if (stop) state <= HALT;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule
